// File: rtl/hub75_scan_reader.sv
// HUB75 scan reader: walks the output buffer row-pair by bit-plane and drives BCM RGB, SCLK, LAT, OE_N.
// Latency: RD_LATENCY+2 cycles from address issue to HUB_RGB; no backpressure, ENABLE low stops at the next plane boundary.
// Optional HUB_BRIGHTNESS_EN adds BRIGHTNESS[7:0] to scale the lit part of each plane.
module hub75_scan_reader #(
    parameter int DATA_WIDTH       = 24,
    parameter int COL_ADDR_WIDTH   = 6,
    parameter int ROW_ADDR_WIDTH   = 5,
    parameter int NUMBER_OF_BLOCKS = 3,
    parameter int COLOR_BITS       = 8,
    parameter int RD_LATENCY       = 2,
    parameter int OE_BASE          = 4
) (
    input  logic                                       OUT_CLK,
    input  logic                                       RESET,
    input  logic                                       ENABLE,
`ifdef HUB_BRIGHTNESS_EN
    input  logic [7:0]                                 BRIGHTNESS,
`endif
    output logic [ROW_ADDR_WIDTH+COL_ADDR_WIDTH-1:0]   OUTBUF_OUT_ADDR,
    input  logic [NUMBER_OF_BLOCKS*DATA_WIDTH-1:0]     OUTBUF_OUT_DATA,
    output logic [6*NUMBER_OF_BLOCKS-1:0]              HUB_RGB,
    output logic [ROW_ADDR_WIDTH-2:0]                  HUB_ROW,
    output logic                                       HUB_SCLK,
    output logic                                       HUB_LAT,
    output logic                                       HUB_OE_N,
    output logic                                       FRAME_START
);

    localparam int HR        = ROW_ADDR_WIDTH - 1;
    localparam int AW        = ROW_ADDR_WIDTH + COL_ADDR_WIDTH;
    localparam int NCOL      = 1 << COL_ADDR_WIDTH;
    localparam int SHIFT_LEN = 2 * NCOL + RD_LATENCY + 2;
    localparam int SW        = $clog2(SHIFT_LEN + 1);
    localparam int OE_MAX    = OE_BASE << (COLOR_BITS - 1);
    localparam int OW        = $clog2(OE_MAX + 1);
    localparam int BW        = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
    localparam int CW        = DATA_WIDTH / 3;
    localparam int NB        = NUMBER_OF_BLOCKS;

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;

    state_t          state_q;
    logic [SW-1:0]   s_q;
    logic [OW-1:0]   d_q;
    logic [HR-1:0]   r_q;
    logic [BW-1:0]   b_q;
    logic [AW-1:0]   addr_q;
    logic [3*NB-1:0] upper_q;
    logic [6*NB-1:0] rgb_q;
    logic [HR-1:0]   row_q;
    logic            sclk_q;
    logic            lat_q;
    logic            oe_n_q;
    logic            fs_q;

    logic [SW-1:0]   s_nx;
    logic [SW-1:0]   s_rel;
    logic            cap_upper;
    logic            cap_lower;
    logic            sclk_d;
    logic            last_plane;
    logic [BW-1:0]   b_nx;
    logic [HR-1:0]   r_nx;
    logic [OW-1:0]   plane_len;
    logic [OW-1:0]   on_len;
    logic [3*NB-1:0] pbits;

    // s_rel is the shift cycle relative to the first returned read word;
    // even offsets carry the upper half row, odd offsets the lower half.
    always_comb begin
        s_nx       = s_q + SW'(1);
        s_rel      = s_q - SW'(RD_LATENCY);
        cap_upper  = (state_q == SHIFT) && (s_q >= SW'(RD_LATENCY)) &&
                     (s_rel < SW'(2 * NCOL)) && !s_rel[0];
        cap_lower  = (state_q == SHIFT) && (s_q >= SW'(RD_LATENCY)) &&
                     (s_rel < SW'(2 * NCOL)) && s_rel[0];
        sclk_d     = (state_q == SHIFT) && (s_q >= SW'(RD_LATENCY + 2)) &&
                     (s_q <= SW'(SHIFT_LEN - 2)) && !s_rel[0];
        last_plane = (b_q == BW'(COLOR_BITS - 1));
        b_nx       = last_plane ? '0 : b_q + BW'(1);
        r_nx       = last_plane ? r_q + HR'(1) : r_q;
        plane_len  = OW'(OE_BASE) << b_q;
    end

    // Per block, bit b of each channel packed as {B,G,R}.
    always_comb begin
        pbits = '0;
        for (int k = 0; k < NB; k++) begin
            for (int i = 0; i < COLOR_BITS; i++) begin
                if (b_q == BW'(i)) begin
                    pbits[3*k +: 3] = {OUTBUF_OUT_DATA[k*DATA_WIDTH + i],
                                       OUTBUF_OUT_DATA[k*DATA_WIDTH + CW + i],
                                       OUTBUF_OUT_DATA[k*DATA_WIDTH + 2*CW + i]};
                end
            end
        end
    end

`ifdef HUB_BRIGHTNESS_EN
    logic [7:0]    bright_q;
    logic [7:0]    bright_sel;
    logic [OW+7:0] on_prod;

    always_comb begin
        bright_sel = (state_q == LATCH) ? BRIGHTNESS : bright_q;
        on_prod    = {8'd0, plane_len} * {{OW{1'b0}}, bright_sel};
        on_len     = OW'(on_prod >> 8);
    end
`else
    assign on_len = plane_len;
`endif

    always_ff @(posedge OUT_CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            s_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            b_q     <= '0;
            addr_q  <= '0;
            upper_q <= '0;
            rgb_q   <= '0;
            row_q   <= '0;
            sclk_q  <= 1'b0;
            lat_q   <= 1'b0;
            oe_n_q  <= 1'b1;
            fs_q    <= 1'b0;
`ifdef HUB_BRIGHTNESS_EN
            bright_q <= '0;
`endif
        end else begin
            fs_q   <= 1'b0;
            lat_q  <= 1'b0;
            sclk_q <= sclk_d;
            if (cap_upper) begin
                upper_q <= pbits;
            end
            if (cap_lower) begin
                for (int k = 0; k < NB; k++) begin
                    rgb_q[6*k +: 6] <= {pbits[3*k +: 3], upper_q[3*k +: 3]};
                end
            end
            unique case (state_q)
                IDLE: begin
                    oe_n_q <= 1'b1;
                    if (ENABLE) begin
                        state_q <= SHIFT;
                        r_q     <= '0;
                        b_q     <= '0;
                        s_q     <= '0;
                        addr_q  <= '0;
                        fs_q    <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (s_q == SW'(SHIFT_LEN - 1)) begin
                        state_q <= LATCH;
                        lat_q   <= 1'b1;
                        rgb_q   <= '0;
                        // Row select only moves at the start of a row, while dark.
                        if (b_q == '0) begin
                            row_q <= r_q;
                        end
                    end else begin
                        s_q <= s_nx;
                        if (s_nx < SW'(2 * NCOL)) begin
                            addr_q <= {s_nx[0], r_q, s_nx[COL_ADDR_WIDTH:1]};
                        end
                    end
                end
                LATCH: begin
                    state_q <= DISPLAY;
                    d_q     <= '0;
                    oe_n_q  <= (on_len == '0);
`ifdef HUB_BRIGHTNESS_EN
                    bright_q <= BRIGHTNESS;
`endif
                end
                DISPLAY: begin
                    if (d_q == plane_len - OW'(1)) begin
                        oe_n_q <= 1'b1;
                        b_q    <= b_nx;
                        r_q    <= r_nx;
                        if (ENABLE) begin
                            state_q <= SHIFT;
                            s_q     <= '0;
                            addr_q  <= {1'b0, r_nx, {COL_ADDR_WIDTH{1'b0}}};
                            fs_q    <= (r_nx == '0) && (b_nx == '0);
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        d_q    <= d_q + OW'(1);
                        oe_n_q <= !((d_q + OW'(1)) < on_len);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign OUTBUF_OUT_ADDR = addr_q;
    assign HUB_RGB         = rgb_q;
    assign HUB_ROW         = row_q;
    assign HUB_SCLK        = sclk_q;
    assign HUB_LAT         = lat_q;
    assign HUB_OE_N        = oe_n_q;
    assign FRAME_START     = fs_q;

endmodule

// File: tb/tb_hub75_scan_reader.sv
// Directed bench for hub75_scan_reader: buffer model with 2-cycle read latency, per-plane timing and data checks.
module tb_hub75_scan_reader;

    localparam int BR = 128;

    logic        out_clk = 1'b0;
    logic        reset   = 1'b1;
    logic        enable  = 1'b0;
    logic [10:0] addr;
    logic [71:0] rd_data = '0;
    logic [71:0] rd_p1   = '0;
    logic [17:0] hub_rgb;
    logic [3:0]  hub_row;
    logic        hub_sclk;
    logic        hub_lat;
    logic        hub_oe_n;
    logic        frame_start;
`ifdef HUB_BRIGHTNESS_EN
    logic [7:0]  brightness = 8'(BR);
`endif

    int mode   = 0;
    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    hub75_scan_reader dut (
        .OUT_CLK         (out_clk),
        .RESET           (reset),
        .ENABLE          (enable),
`ifdef HUB_BRIGHTNESS_EN
        .BRIGHTNESS      (brightness),
`endif
        .OUTBUF_OUT_ADDR (addr),
        .OUTBUF_OUT_DATA (rd_data),
        .HUB_RGB         (hub_rgb),
        .HUB_ROW         (hub_row),
        .HUB_SCLK        (hub_sclk),
        .HUB_LAT         (hub_lat),
        .HUB_OE_N        (hub_oe_n),
        .FRAME_START     (frame_start)
    );

    always #5 out_clk = ~out_clk;

    // Pattern 0: block0 upper half red, rest black. Pattern 1: 0x010000 in every pixel.
    function automatic logic [71:0] mem_word(input logic [10:0] a, input int m);
        logic [4:0] row;
        row = a[10:6];
        if (m == 0) return (row < 5'd16) ? 72'hFF0000 : 72'h0;
        return {24'h010000, 24'h010000, 24'h010000};
    endfunction

    always @(posedge out_clk) begin
        cyc     <= cyc + 1;
        rd_p1   <= mem_word(addr, mode);
        rd_data <= rd_p1;
    end

    function automatic int exp_on(input int b);
`ifdef HUB_BRIGHTNESS_EN
        return ((4 << b) * BR) >> 8;
`else
        return 4 << b;
`endif
    endfunction

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        chk({pfx, "_addr"}, addr, 0);
        chk({pfx, "_rgb"},  hub_rgb, 0);
        chk({pfx, "_row"},  hub_row, 0);
        chk({pfx, "_sclk"}, hub_sclk, 0);
        chk({pfx, "_lat"},  hub_lat, 0);
        chk({pfx, "_oe_n"}, hub_oe_n, 1);
        chk({pfx, "_fs"},   frame_start, 0);
    endtask

    task automatic wait_fs(input string tag);
        int n = 0;
        while (!frame_start && n < 20) begin
            @(negedge out_clk);
            n++;
        end
        chk(tag, frame_start, 1);
    endtask

    // Entered at the negedge of the first SHIFT cycle; leaves at the next plane's first cycle.
    task automatic plane(input int r, input int b, input logic [17:0] exp_rgb);
        int len, on, nsclk, nlat, latidx, lastsclk, nbada, nbadrgb, noe, noe_out, nrow, nfs, rowlat, exp_a;
        logic prev_sclk, fs0;
        logic [3:0] row_prev;
        len = 133 + (4 << b);
        on = exp_on(b);
        nsclk = 0; nlat = 0; latidx = -1; lastsclk = -1; nbada = 0; nbadrgb = 0;
        noe = 0; noe_out = 0; nrow = 0; nfs = 0; rowlat = -1;
        prev_sclk = 1'b0; fs0 = 1'b0;
        row_prev = hub_row;
        for (int i = 0; i < len; i++) begin
            if (i < 128) begin
                exp_a = (((i % 2) == 1) ? (16 + r) : r) * 64 + i / 2;
                if (int'(addr) != exp_a) nbada++;
            end
            if (i == 0) fs0 = frame_start;
            else if (frame_start) nfs++;
            if (hub_sclk) begin
                if (!prev_sclk) nsclk++;
                lastsclk = i;
                if (hub_rgb != exp_rgb) nbadrgb++;
            end
            prev_sclk = hub_sclk;
            if (hub_lat) begin
                nlat++;
                latidx = i;
                rowlat = int'(hub_row);
            end
            if (!hub_oe_n) begin
                noe++;
                if (i < 133 || i >= 133 + on) noe_out++;
                if (hub_row != row_prev) nrow++;
            end
            row_prev = hub_row;
            @(negedge out_clk);
        end
        chk($sformatf("fs r%0d b%0d", r, b), fs0, (r == 0 && b == 0) ? 1 : 0);
        chk($sformatf("fs_extra r%0d b%0d", r, b), nfs, 0);
        chk($sformatf("addr_bad r%0d b%0d", r, b), nbada, 0);
        chk($sformatf("sclk_rises r%0d b%0d", r, b), nsclk, 64);
        chk($sformatf("last_sclk r%0d b%0d", r, b), lastsclk, 131);
        chk($sformatf("rgb_bad r%0d b%0d", r, b), nbadrgb, 0);
        chk($sformatf("lat_cnt r%0d b%0d", r, b), nlat, 1);
        chk($sformatf("lat_idx r%0d b%0d", r, b), latidx, 132);
        chk($sformatf("row r%0d b%0d", r, b), rowlat, r);
        chk($sformatf("oe_low r%0d b%0d", r, b), noe, on);
        chk($sformatf("oe_window r%0d b%0d", r, b), noe_out, 0);
        chk($sformatf("row_lit r%0d b%0d", r, b), nrow, 0);
    endtask

    initial begin
        int t0, nlat, noe, nsclk, nfs;
        // Reset state
        repeat (2) @(negedge out_clk);
        check_reset_vals("rst");
        reset = 1'b0;
        repeat (3) @(negedge out_clk);
        chk("idle_oe_n", hub_oe_n, 1);
        chk("idle_fs", frame_start, 0);

        // Frame 1: red upper half on block 0 only
        enable = 1'b1;
        wait_fs("fs_first");
        chk("addr_first", addr, 0);
        t0 = cyc;
        for (int r = 0; r < 16; r++)
            for (int b = 0; b < 8; b++)
                plane(r, b, 18'h00001);
        chk("frame_period", cyc - t0, 33344);

        // Frame 2: LSB-only red everywhere
        mode = 1;
        t0 = cyc;
        for (int r = 0; r < 16; r++)
            for (int b = 0; b < 8; b++)
                plane(r, b, (b == 0) ? 18'h09249 : 18'h0);
        chk("frame_period2", cyc - t0, 33344);
        chk("fs_frame3", frame_start, 1);

        // ENABLE dropped mid-SHIFT: plane 0 finishes, then idle
        repeat (50) @(negedge out_clk);
        enable = 1'b0;
        nlat = 0; noe = 0;
        for (int i = 50; i < 137; i++) begin
            if (hub_lat) nlat++;
            if (!hub_oe_n) noe++;
            @(negedge out_clk);
        end
        chk("drop_lat", nlat, 1);
        chk("drop_oe_low", noe, exp_on(0));
        nsclk = 0; noe = 0; nfs = 0;
        for (int i = 0; i < 200; i++) begin
            if (hub_sclk) nsclk++;
            if (!hub_oe_n) noe++;
            if (frame_start) nfs++;
            @(negedge out_clk);
        end
        chk("idle_sclk", nsclk, 0);
        chk("idle_oe_low", noe, 0);
        chk("idle_fs_cnt", nfs, 0);

        // Restart begins at row 0 plane 0
        enable = 1'b1;
        wait_fs("fs_restart");
        plane(0, 0, 18'h09249);

        // Reset in the middle of plane 1 DISPLAY
        repeat (134) @(negedge out_clk);
        chk("oe_pre_reset", hub_oe_n, 0);
        #1 reset = 1'b1;
        #1 check_reset_vals("async_rst");
        enable = 1'b0;
        repeat (2) @(negedge out_clk);
        reset = 1'b0;
        repeat (3) @(negedge out_clk);
        chk("post_rst_oe_n", hub_oe_n, 1);
        chk("post_rst_sclk", hub_sclk, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
